modadder_arbiter: RTL
=====================

# modadder_arbiter

Round-robin arbiter and sequencer that shares one 381-bit modular adder/subtractor among `N_REQ` requesters (point-arithmetic FSM, Montgomery pre/post-processing, verify-loop control). It accepts one operation at a time over a valid/ready handshake, latches the operands and holds them stable, and pulses the adder start. It then waits for the adder done, independent of the adder latency, and returns the result to the granted requester with a one-cycle response pulse. A watchdog flags an adder that never completes.

## Interface
- `N_REQ`, 3, number of requesters (2..8)
- `W`, 381, operand/result width
- `TIMEOUT`, 64, max cycles spent in WAIT before error
- `clk` in 1, clock
- `resetn` in 1, asynchronous, active-low reset
- `req_valid` in N_REQ, request pending per requester
- `req_ready` out N_REQ, one-hot grant; handshake when `req_valid[i] & req_ready[i]`
- `req_a` in N_REQ*W, operand A, requester i at `[i*W +: W]`
- `req_b` in N_REQ*W, operand B, same packing
- `req_sub` in N_REQ, 1 = A−B mod M, 0 = A+B mod M
- `mod_m` in W, modulus; quasi-static, must not change while `busy`
- `rsp_valid` out N_REQ, one-cycle pulse to the granted requester
- `rsp_result` out W, result; valid when any `rsp_valid` bit is high
- `rsp_err` out 1, qualifies `rsp_valid`: operation timed out
- `busy` out 1, high in every state except IDLE
- `err_sticky` out 1, set on any timeout, cleared only by reset
- `add_a`, `add_b`, `add_m` out W, adder operands
- `add_sub` out 1, adder mode
- `add_start` out 1, one-cycle start pulse
- `add_result` in W, adder result, sampled only in the `add_done` cycle
- `add_done` in 1, adder completion pulse

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, select the winner round-robin. The search starts at `last_grant+1` and wraps modulo `N_REQ`.
  - Drive `req_ready` one-hot combinationally for the winner only.
  - On the handshake, latch `a_q`, `b_q`, `sub_q` and `grant_q`, then go to ISSUE.
  - `req_ready` is 0 in all other states.
- **ISSUE**: `add_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - On `add_done`: capture `add_result` into `res_q`, clear `err_q`, go to RESP.
  - Otherwise increment `tmo_cnt`. When `tmo_cnt == TIMEOUT-1` with no done: `res_q`=0, `err_q`=1, set `err_sticky`, go to RESP.
- **RESP**
  - `rsp_valid[grant_q]`=1, `rsp_err`=`err_q`.
  - `last_grant` ← `grant_q`, `tmo_cnt` ← 0, go to IDLE.
- Operand hold rules:
  - `add_a`, `add_b`, `add_sub` are driven from `a_q`, `b_q`, `sub_q`.
  - These registers hold from ISSUE through the `add_done` cycle inclusive, because the adder uses `add_sub` and the operands at completion.
  - `add_m` = `mod_m` directly.
- `rsp_result` = `res_q`; it holds its value until the next capture.
- No arithmetic in this block. Operand range (A, B < M) is the requester's responsibility.
- Stray `add_done` outside WAIT is ignored.

## Timing
- Reset values:
  - State IDLE; all `req_ready`, `rsp_valid`, `add_start` = 0; `rsp_err`, `busy`, `err_sticky` = 0.
  - `a_q`, `b_q`, `res_q` = 0; `sub_q` = 0; `tmo_cnt` = 0.
  - `last_grant` = `N_REQ-1`, so requester 0 has first priority.
- Handshake in cycle T → `add_start` at T+1 → `add_done` at T+1+L (L = adder latency, ≥1) → `rsp_valid` at T+2+L.
- Next grant is possible at T+3+L earliest.
- `req_valid` may drop at any time before the handshake with no effect. After the handshake the operation always completes.
- Several `req_valid` bits high in IDLE: exactly one is granted. Under continuous load the others are served in strict rotation, with no starvation.
- `add_done` in the same cycle as `tmo_cnt` reaching `TIMEOUT-1`: done wins, no error.
- Reset mid-operation: immediate return to reset values and the in-flight request is dropped without a response. The adder shares `resetn`.

## Test plan
- Single add: req 0, A=5, B=7, M=11, sub=0; adder model L=3. Required: `add_start` one cycle after the handshake; `rsp_valid`=3'b001 with `rsp_result`=1 at T+5; `busy` high T+1..T+5.
- Single subtract: req 2, A=3, B=9, M=11, sub=1. Required: `rsp_result`=5, `rsp_valid`=3'b100, `add_sub`=1 held through `add_done`.
- Contention: all three valid continuously with distinct operands. Required: grant order 0,1,2,0,1,2; each response goes to the matching requester with the correct result.
- Timeout: adder model never asserts done, `TIMEOUT`=64. Required: `rsp_valid` with `rsp_err`=1 and `rsp_result`=0 exactly 64 cycles after `add_start`; `err_sticky`=1; the next request then completes normally with `rsp_err`=0.
- Reset mid-WAIT: assert `resetn`=0 two cycles after `add_start`. Required: all outputs return to reset values immediately; no `rsp_valid`; requester 0 is granted first after release.

Source files
------------

// File: rtl/modadder_arbiter_if.sv
// Requester, response, status and adder-side signals of the shared modular adder arbiter.
interface modadder_arbiter_if #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned W     = 381
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ-1:0]   req_sub;
    logic [W-1:0]       mod_m;
    logic [N_REQ-1:0]   rsp_valid;
    logic [W-1:0]       rsp_result;
    logic               rsp_err;
    logic               busy;
    logic               err_sticky;
    logic [W-1:0]       add_a;
    logic [W-1:0]       add_b;
    logic [W-1:0]       add_m;
    logic               add_sub;
    logic               add_start;
    logic [W-1:0]       add_result;
    logic               add_done;

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, req_sub, mod_m, add_result, add_done,
        output req_ready, rsp_valid, rsp_result, rsp_err, busy, err_sticky,
               add_a, add_b, add_m, add_sub, add_start
    );

    // Requester / adder side.
    modport master (
        output req_valid, req_a, req_b, req_sub, mod_m, add_result, add_done,
        input  req_ready, rsp_valid, rsp_result, rsp_err, busy, err_sticky,
               add_a, add_b, add_m, add_sub, add_start
    );
endinterface

// File: rtl/modadder_arbiter.sv
// Round-robin sequencer sharing one modular adder/subtractor among N_REQ requesters,
// with operand hold, done-wait and a timeout watchdog.
module modadder_arbiter #(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned W       = 381,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              resetn,
    modadder_arbiter_if.slave bus
);
    localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  res_q;
    logic          sub_q;
    logic          err_q;
    logic          err_sticky_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] last_grant;
    logic [TW-1:0] tmo_cnt;
    logic [GW-1:0] win;
    logic          win_found;
    logic [GW:0]   idx;
    logic          hs;
    logic          tmo_hit;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = {1'b0, last_grant} + (GW+1)'(off);
            if (idx >= (GW+1)'(N_REQ)) begin
                idx = idx - (GW+1)'(N_REQ);
            end
            if (!win_found && bus.req_valid[idx[GW-1:0]]) begin
                win_found = 1'b1;
                win       = idx[GW-1:0];
            end
        end
    end

    assign hs      = (state == S_IDLE) && win_found;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (hs) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (bus.add_done || tmo_hit) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.add_start = 1'b0;
        bus.busy      = 1'b1;
        bus.rsp_valid = '0;
        bus.rsp_err   = 1'b0;
        case (state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (win_found) bus.req_ready = N_REQ'(1) << win;
            end
            S_ISSUE: bus.add_start = 1'b1;
            S_RESP: begin
                bus.rsp_valid = N_REQ'(1) << grant_q;
                bus.rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    // Operand latch, result capture and watchdog; tmo_cnt counts cycles since add_start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            sub_q        <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            grant_q      <= '0;
            last_grant   <= GW'(N_REQ - 1);
            tmo_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        a_q     <= bus.req_a[int'(win) * W +: W];
                        b_q     <= bus.req_b[int'(win) * W +: W];
                        sub_q   <= bus.req_sub[win];
                        grant_q <= win;
                    end
                end
                S_ISSUE: tmo_cnt <= tmo_cnt + TW'(1);
                S_WAIT: begin
                    if (bus.add_done) begin
                        res_q <= bus.add_result;
                        err_q <= 1'b0;
                    end else if (tmo_hit) begin
                        res_q        <= '0;
                        err_q        <= 1'b1;
                        err_sticky_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_RESP: begin
                    last_grant <= grant_q;
                    tmo_cnt    <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.add_a      = a_q;
    assign bus.add_b      = b_q;
    assign bus.add_sub    = sub_q;
    assign bus.add_m      = bus.mod_m;
    assign bus.rsp_result = res_q;
    assign bus.err_sticky = err_sticky_q;

endmodule
